// File: rtl/tanh_arbiter_pkg.sv
// Shared fixed-point format for the tanh datapath: signed Q3.5 words.
// Nothing in the arbiter interprets the fraction; it only sizes the buses.
package tanh_arbiter_pkg;
    localparam int FXP_W    = 9;
    localparam int FXP_FRAC = 5;

    function automatic logic signed [FXP_W-1:0] fxp_one();
        return FXP_W'(1 << FXP_FRAC);
    endfunction
endpackage

// File: rtl/tanh_arbiter_rr_arbiter.sv
// Round-robin winner select: purely combinational, zero latency, no backpressure.
// The search starts at i_ptr and wraps from N_REQ-1 back to 0.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic [N_REQ-1:0]         o_grant
);
    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = PTR_W'((int'(i_ptr) + k) % N_REQ);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/tanh_arbiter.sv
// Shares one combinational tanh lookup unit among N_REQ requesters.
// Result appears 2 cycles after accept; accepts nothing while a result waits on rsp_ready.
module tanh_arbiter
    import tanh_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = FXP_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req_valid,
    input  logic [N_REQ*DATA_W-1:0]   i_req_data,
    output logic [N_REQ-1:0]          o_req_ready,
    output logic signed [DATA_W-1:0]  o_lut_in,
    input  logic signed [DATA_W-1:0]  i_lut_out,
    output logic                      o_rsp_valid,
    output logic [$clog2(N_REQ)-1:0]  o_rsp_id,
    output logic signed [DATA_W-1:0]  o_rsp_data,
    input  logic                      i_rsp_ready,
    output logic                      o_busy
);
    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [ID_W-1:0]           r_ptr;
    logic [ID_W-1:0]           r_id;
    logic signed [DATA_W-1:0]  r_op;
    logic signed [DATA_W-1:0]  r_rsp_data;

    logic [N_REQ-1:0]          w_grant;
    logic [ID_W-1:0]           w_gnt_idx;
    logic [ID_W-1:0]           w_ptr_nxt;
    logic signed [DATA_W-1:0]  w_op_sel;
    logic                      w_accept;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    always_comb begin
        w_gnt_idx = '0;
        w_op_sel  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_gnt_idx = ID_W'(i);
                w_op_sel  = i_req_data[i*DATA_W +: DATA_W];
            end
        end
        w_ptr_nxt = (w_gnt_idx == ID_W'(N_REQ-1)) ? '0 : w_gnt_idx + ID_W'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = '0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Ready is forced low during reset so nothing can look accepted.
                o_req_ready = i_rst ? '0 : w_grant;
                w_accept    = |w_grant;
                if (w_accept) w_state_nxt = S_LOOKUP;
            end
            S_LOOKUP: w_state_nxt = S_RESP;
            S_RESP:   if (i_rsp_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_id       <= '0;
            r_op       <= '0;
            r_rsp_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op  <= w_op_sel;
                r_id  <= w_gnt_idx;
                r_ptr <= w_ptr_nxt;
            end
            if (r_state == S_LOOKUP) r_rsp_data <= i_lut_out;
        end
    end

    // The lookup unit sees only the latched operand, never the live request bus.
    assign o_lut_in    = r_op;
    assign o_rsp_valid = (r_state == S_RESP);
    assign o_rsp_id    = r_id;
    assign o_rsp_data  = r_rsp_data;
    assign o_busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_tanh_arbiter.sv
// Scoreboard bench for tanh_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of round-robin service.
module tb_tanh_arbiter;
    localparam int N = 4;
    localparam int W = 9;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          req_valid;
    logic [N*W-1:0]        req_data;
    logic [N-1:0]          req_ready;
    logic signed [W-1:0]   lut_in;
    logic signed [W-1:0]   lut_out;
    logic                  rsp_valid;
    logic [$clog2(N)-1:0]  rsp_id;
    logic signed [W-1:0]   rsp_data;
    logic                  rsp_ready;
    logic                  busy;

    tanh_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_lut_in    (lut_in),
        .i_lut_out   (lut_out),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_data  (rsp_data),
        .i_rsp_ready (rsp_ready),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    // Stand-in lookup unit: roughly 3/4 slope, with 32 -> 25 pinned.
    function automatic logic signed [W-1:0] lut_fn(input logic signed [W-1:0] x);
        if (x == 9'sd32) return 9'sd25;
        return x - (x >>> 2);
    endfunction

    assign lut_out = lut_fn(lut_in);

    typedef struct {
        int                  id;
        logic signed [W-1:0] op;
        logic signed [W-1:0] res;
    } exp_t;

    int   n_checks = 0;
    int   n_err    = 0;
    int   resp_count = 0;
    int   cyc = 0;
    int   last_id = -1;
    int   last_data = 0;
    int   grant_log[$];
    int   grant_cyc[$];
    exp_t exp_q[$];

    // Model state: next requester to search from, and transaction phase
    // (0 waiting for a request, 1 lookup cycle, 2 result offered).
    int   m_ptr = 0;
    int   m_phase = 0;

    task automatic check(input string name, input int act, input int want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, want, $time);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        int   w;
        exp_t e;
        cyc++;
        if (rst) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_busy", busy, 0);
            m_ptr   = 0;
            m_phase = 0;
            exp_q.delete();
        end else begin
            if (req_ready != '0) begin
                grant_log.push_back(oh_idx(req_ready));
                grant_cyc.push_back(cyc);
            end
            case (m_phase)
                0: begin
                    w = -1;
                    for (int k = 0; k < N; k++) begin
                        int idx;
                        idx = (m_ptr + k) % N;
                        if (w < 0 && req_valid[idx]) w = idx;
                    end
                    check("grant", req_ready, (w < 0) ? 0 : (1 << w));
                    check("idle_rsp_valid", rsp_valid, 0);
                    check("idle_busy", busy, 0);
                    if (w >= 0) begin
                        e.id  = w;
                        e.op  = req_data[w*W +: W];
                        e.res = lut_fn(e.op);
                        exp_q.push_back(e);
                        m_ptr   = (w + 1) % N;
                        m_phase = 1;
                    end
                end
                1: begin
                    check("lookup_req_ready", req_ready, 0);
                    check("lookup_rsp_valid", rsp_valid, 0);
                    check("lookup_busy", busy, 1);
                    check("lookup_lut_in", lut_in, exp_q[0].op);
                    m_phase = 2;
                end
                default: begin
                    check("resp_req_ready", req_ready, 0);
                    check("resp_rsp_valid", rsp_valid, 1);
                    check("resp_busy", busy, 1);
                    check("resp_id", rsp_id, exp_q[0].id);
                    check("resp_data", rsp_data, exp_q[0].res);
                    if (rsp_ready) begin
                        last_id   = rsp_id;
                        last_data = rsp_data;
                        void'(exp_q.pop_front());
                        resp_count++;
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    logic [N-1:0] acc;
    bit           rand_mode = 0;
    bit           refill = 0;

    // One clock of requester behaviour: accepted requests are retired after the edge.
    task automatic step();
        @(negedge clk);
        #1 acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
        for (int i = 0; i < N; i++) begin
            if (refill && acc[i]) begin
                req_valid[i]         = 1'b1;
                req_data[i*W +: W]   = W'($urandom_range(0, 511));
            end
            if (rand_mode) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req_valid[i]       = 1'b1;
                        req_data[i*W +: W] = W'($urandom_range(0, 511));
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        if (rand_mode) rsp_ready = $urandom_range(0, 1) == 1;
    endtask

    task automatic wait_resp(input int target, input string name);
        int c;
        c = 0;
        while (resp_count < target && c < 100) begin
            step();
            c++;
        end
        check(name, resp_count >= target, 1);
    endtask

    int base;
    int gbefore;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single request on requester 2, operand 32 -> 25
        req_data[2*W +: W] = 9'sd32;
        req_valid = 4'b0100;
        wait_resp(1, "single_done");
        check("single_grant", grant_log[0], 2);
        check("single_id", last_id, 2);
        check("single_data", last_data, 25);

        // Negative operand passes through bit-exact
        req_data[0 +: W] = -9'sd64;
        req_valid = 4'b0001;
        wait_resp(2, "neg_done");
        check("neg_grant", grant_log[1], 0);
        check("neg_data", last_data, -48);

        // Move pointer to 3, then requests on 1 and 3: expect 3 then 1, pointer 2
        req_valid = 4'b0100;
        wait_resp(3, "wrap_setup");
        req_valid = 4'b1010;
        wait_resp(5, "wrap_done");
        check("wrap_first", grant_log[3], 3);
        check("wrap_second", grant_log[4], 1);
        req_valid = 4'b1111;
        wait_resp(6, "wrap_ptr_done");
        check("wrap_ptr_next", grant_log[5], 2);
        req_valid = '0;

        // Backpressure: result held for 5 cycles with nothing new accepted
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        begin
            int c;
            c = 0;
            while (!rsp_valid && c < 20) begin
                step();
                c++;
            end
        end
        check("bp_rsp_seen", rsp_valid, 1);
        gbefore = grant_log.size();
        repeat (5) step();
        check("bp_no_accept", grant_log.size(), gbefore);
        check("bp_still_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        wait_resp(7, "bp_release");
        check("bp_id", last_id, 0);
        wait_resp(8, "bp_followup");
        check("bp_follow_id", last_id, 1);
        req_valid = '0;

        // Reset during LOOKUP discards the request; then fairness from requester 0
        req_valid = 4'b0100;
        begin
            int c;
            c = 0;
            while (!(busy && !rsp_valid) && c < 20) begin
                step();
                c++;
            end
        end
        check("lookup_seen", busy && !rsp_valid, 1);
        rst       = 1'b1;
        req_valid = 4'b1111;
        refill    = 1;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_discard", resp_count, 8);
        base = grant_log.size();
        wait_resp(13, "fair_done");
        for (int k = 0; k < 5; k++) begin
            check("fair_order", grant_log[base+k], exp_order[k]);
            if (k > 0) check("fair_spacing", grant_cyc[base+k] - grant_cyc[base+k-1], 3);
        end
        refill    = 0;
        req_valid = '0;

        // Randomized traffic with random backpressure and request withdrawal
        rand_mode = 1;
        repeat (400) step();
        rand_mode = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        begin
            int c;
            c = 0;
            while (busy && c < 10) begin
                step();
                c++;
            end
        end
        check("drain_idle", busy, 0);
        check("drain_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
